// File: rtl/instmem_loader.sv
// Instruction-memory loader: takes a byte stream and packs it into big-endian
// 32-bit words. Each word is written to instruction memory starting at
// BASE_ADDR. busy stays high for the whole load so that the CPU fetch stalls.
module instmem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] len_bytes,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [13:0] DEPTH_L = 14'(DEPTH_BYTES);

  state_t      state;
  logic [12:0] len_q;
  logic [12:0] cnt;
  logic [11:0] offset;
  logic [31:0] word;

  logic [31:0] word_ins;
  logic [12:0] cnt_inc;
  logic        len_ok;
  logic        word_full;

  // Drop the incoming byte into its lane. Byte 0 of a word goes to [31:24].
  // Byte 3 goes to [7:0]. The lane index (3 - cnt[1:0]) is ~cnt[1:0].
  always_comb begin
    word_ins = word;
    word_ins[{~cnt[1:0], 3'b000} +: 8] = byte_data;
  end

  assign cnt_inc   = cnt + 13'd1;
  assign len_ok    = (len_bytes != 13'd0) && ({1'b0, len_bytes} <= DEPTH_L);
  // A word is flushed once its 4th lane fills or the program runs out.
  assign word_full = (cnt[1:0] == 2'd3) || (cnt_inc == len_q);

  // Load sequencer. All outputs are registered and updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      offset     <= '0;
      word       <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q      <= len_bytes;
              cnt        <= '0;
              offset     <= '0;
              word       <= '0;
              err        <= 1'b0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              state      <= RECV;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_valid && byte_ready) begin
            cnt  <= cnt_inc;
            word <= word_ins;
            if (word_full) begin
              byte_ready <= 1'b0;
              we         <= 1'b1;
              wa         <= BASE_ADDR + {20'd0, offset};
              wd         <= word_ins;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          we     <= 1'b0;
          wa     <= '0;
          wd     <= '0;
          offset <= offset + 12'd4;
          word   <= '0;
          if (cnt == len_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            byte_ready <= 1'b1;
            state      <= RECV;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          byte_ready <= 1'b0;
          we         <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instmem_loader.sv
// Bench for instmem_loader. It feeds directed and random byte streams. A
// reference model builds the expected word writes directly from the program
// bytes, and a per-cycle monitor checks every DUT write against that list.
module tb_instmem_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] len_bytes = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, we, busy, done, err;
  logic [31:0] wa, wd;

  instmem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_bytes(len_bytes),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic        prev_we = 1'b0;
  logic [7:0]  prog [4096];
  logic [31:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [31:0] log_wa [$];
  logic [31:0] log_wd [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Word i of a program of len bytes: bytes in address order, shifted in from
  // the right, missing tail bytes as zero.
  function automatic logic [31:0] model_word(input int len, input int i);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      w = w << 8;
      if (4 * i + b < len) w[7:0] = prog[4 * i + b];
    end
    return w;
  endfunction

  task automatic expect_load(input int len);
    for (int i = 0; i * 4 < len; i++) begin
      exp_wa.push_back(BASE + 32'(4 * i));
      exp_wd.push_back(model_word(len, i));
    end
  endtask

  // Per-cycle monitor: checks writes against the model and keeps idle outputs quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        log_wa.push_back(wa);
        log_wd.push_back(wd);
        chk1("we_expected", exp_wa.size() > 0, 1'b1);
        if (exp_wa.size() > 0) begin
          chk("wa", wa, exp_wa.pop_front());
          chk("wd", wd, exp_wd.pop_front());
        end
        chk1("we_single_cycle", prev_we, 1'b0);
      end
      if (!busy) begin
        chk("idle_ctrl", {29'd0, byte_ready, we, done}, 32'd0);
        chk("idle_wa", wa, 32'd0);
        chk("idle_wd", wd, 32'd0);
      end
      if (byte_ready) chk1("ready_implies_busy", busy, 1'b1);
      if (done) begin
        chk("done_no_pending", 32'(exp_wa.size()), 32'd0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_we = we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) prog[i] = 8'($urandom);
  endtask

  // mode 0: continuous bytes, 1: random gaps, 2: valid every other cycle
  task automatic run_load(input int len, input int mode, input bit poke, output int lat);
    int idx;
    int guard;
    int d0;
    int acc;
    bit v;
    idx = 0;
    guard = 0;
    expect_load(len);
    @(negedge clk);
    start = 1'b1;
    len_bytes = 13'(len);
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    d0 = done_cnt;
    chk1("start_accepted_busy", busy, 1'b1);
    chk1("start_clears_err", err, 1'b0);
    while (idx < len && guard < 20000) begin
      case (mode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 3) != 0);
        default: v = (guard % 2 == 0);
      endcase
      if (mode == 2) chk1("ready_held", byte_ready, 1'b1);
      start = poke && (guard == 3);
      len_bytes = (poke && guard == 3) ? 13'd1 : 13'(len);
      byte_valid = v;
      byte_data = prog[idx];
      if (v && byte_ready) idx++;
      @(negedge clk);
      guard++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    chk("bytes_accepted", 32'(idx), 32'(len));
    #1;
    guard = 0;
    while (done_cnt == d0 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    lat = done_cyc - acc + 1;
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk1("busy_after_done", busy, 1'b0);
    chk("writes_drained", 32'(exp_wa.size()), 32'd0);
  endtask

  task automatic reject(input logic [12:0] l);
    @(negedge clk);
    start = 1'b1;
    len_bytes = l;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk1("reject_err", err, 1'b1);
    chk1("reject_busy", busy, 1'b0);
    chk1("reject_ready", byte_ready, 1'b0);
  endtask

  initial begin
    int lat;
    int w0;
    int d0;
    logic [7:0] p34 [8] = '{8'h13, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13};
    logic [7:0] p35 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    #1;
    chk("reset_ctrl", {25'd0, byte_ready, we, busy, done, err, 2'b00}, 32'd0);
    chk("reset_wa", wa, 32'd0);
    chk("reset_wd", wd, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk1("no_activity_without_start", busy, 1'b0);
    chk1("no_ready_without_start", byte_ready, 1'b0);
    byte_valid = 1'b0;

    // Two full words, continuous
    for (int i = 0; i < 8; i++) prog[i] = p34[i];
    w0 = log_wa.size();
    run_load(8, 0, 1'b0, lat);
    chk("lat_len8", 32'(lat), 32'd11);
    chk("w0_addr", log_wa[w0], 32'hBFC00000);
    chk("w0_data", log_wd[w0], 32'h13000093);
    chk("w1_addr", log_wa[w0 + 1], 32'hBFC00004);
    chk("w1_data", log_wd[w0 + 1], 32'h00100013);

    // Partial final word
    for (int i = 0; i < 6; i++) prog[i] = p35[i];
    w0 = log_wa.size();
    run_load(6, 0, 1'b0, lat);
    chk("lat_len6", 32'(lat), 32'd9);
    chk("partial_addr", log_wa[w0 + 1], 32'hBFC00004);
    chk("partial_data", log_wd[w0 + 1], 32'hEEFF0000);

    // Out-of-range lengths, then a good start clears err
    reject(13'd0);
    reject(13'd4097);
    reject(13'd8191);
    fill_rand(4);
    run_load(4, 0, 1'b0, lat);

    // Gapped valid keeps ready high
    fill_rand(4);
    run_load(4, 2, 1'b0, lat);

    // Reset after two of four bytes
    fill_rand(4);
    @(negedge clk);
    start = 1'b1;
    len_bytes = 13'd4;
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = prog[0];
    @(negedge clk);
    byte_data = prog[1];
    @(negedge clk);
    byte_valid = 1'b0;
    chk1("busy_before_reset", busy, 1'b1);
    d0 = done_cnt;
    w0 = log_wa.size();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {25'd0, byte_ready, we, busy, done, err, 2'b00}, 32'd0);
    chk("abort_wa", wa, 32'd0);
    chk("abort_wd", wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_write", 32'(log_wa.size() - w0), 32'd0);
    fill_rand(4);
    w0 = log_wa.size();
    run_load(4, 0, 1'b0, lat);
    chk("after_abort_addr", log_wa[w0], BASE);

    // start pulsed mid-load is ignored
    fill_rand(12);
    run_load(12, 0, 1'b1, lat);
    chk("lat_poke", 32'(lat), 32'd16);

    // Random lengths with random gaps
    for (int k = 0; k < 8; k++) begin
      int l;
      l = $urandom_range(1, 40);
      fill_rand(l);
      run_load(l, 1, 1'b0, lat);
    end

    // Full-capacity load
    fill_rand(4096);
    run_load(4096, 0, 1'b0, lat);
    chk("lat_full", 32'(lat), 32'd5121);
    chk("last_addr", log_wa[log_wa.size() - 1], 32'hBFC00FFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instmem_loader.md
INSTMEM_LOADER -- requirements
Module: instmem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'hBFC00000, byte address of the first instruction-memory location written.
REQ-002 Parameter DEPTH_BYTES, default 4096, instruction-memory capacity in bytes (12-bit offset space).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 len_bytes  input  13  number of program bytes to load; sampled when start is accepted.
REQ-007 byte_valid  input  1  producer has a byte on byte_data.
REQ-008 byte_data  input  8  program byte, in memory order (lowest address first).
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 we  output  1  instruction-memory word write strobe.
REQ-011 wa  output  32  byte address of the word written; always 4-byte aligned.
REQ-012 wd  output  32  write data; byte at wa in wd[31:24], wa+3 in wd[7:0] (big-endian by address, matching fetch assembly).
REQ-013 busy  output  1  load in progress; used as CPU fetch stall.
REQ-014 done  output  1  one-cycle pulse on load completion.
REQ-015 err  output  1  sticky error flag; cleared by the next accepted start.

Function
REQ-016 FSM states SHALL be IDLE, RECV, WRITE, DONE.
REQ-017 IDLE: start=1 with 1 <= len_bytes <= DEPTH_BYTES -> latch length, clear byte count, offset, word register and err, go RECV.
REQ-018 IDLE: start=1 with len_bytes=0 or len_bytes > DEPTH_BYTES -> set err=1, remain IDLE, no write, no done.
REQ-019 start while not IDLE SHALL be ignored.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte transfers on any clk edge with byte_valid=1 and byte_ready=1.
REQ-021 Each accepted byte SHALL fill the next lane, MSB lane first; byte count increments by 1.
REQ-022 RECV -> WRITE on the edge accepting the 4th byte of a word or the final byte (count reaches length).
REQ-023 Partial final word: unfilled low lanes SHALL be 8'h00.
REQ-024 WRITE: we=1 for exactly one cycle, wa=BASE_ADDR+offset, wd=assembled word; on exit offset += 4 and word register clears.
REQ-025 WRITE -> DONE if byte count equals latched length, else -> RECV.
REQ-026 DONE: done=1 for one cycle, then -> IDLE.
REQ-027 busy SHALL be 1 in RECV, WRITE, DONE; 0 in IDLE.
REQ-028 Throughput: a full word costs 4 RECV cycles (byte_valid held high) plus 1 WRITE cycle; byte_valid gaps stall RECV without state loss.
REQ-029 Offset SHALL be 12 bits; wa never exceeds BASE_ADDR+DEPTH_BYTES-4; no wrap occurs because length is range-checked.
REQ-030 we, wa, wd SHALL be driven from registered state; wa and wd are don't-care when we=0 but SHALL be held at 0 in IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and byte_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, with all counters and word register cleared.
REQ-032 Reset mid-load SHALL abort without completing the partial word write; no done pulse.
REQ-033 After rst_n release, the first activity SHALL be an accepted start.

Verification
REQ-034 start, len_bytes=8, bytes 13,00,00,93,00,10,00,13 continuous -> writes 32'h13000093 at BFC00000 and 32'h00100013 at BFC00004, done pulse on cycle 11 after start accepted.
REQ-035 start, len_bytes=6, bytes AA,BB,CC,DD,EE,FF -> second write wa=BFC00004, wd=32'hEEFF0000, then done.
REQ-036 start with len_bytes=0, then len_bytes=4097 -> err=1 each time, busy=0, no we; next valid start clears err.
REQ-037 len_bytes=4, byte_valid toggled every other cycle -> byte_ready stays 1, single write after 4th byte, done=1 once.
REQ-038 Assert rst_n=0 after 2 of 4 bytes -> all outputs 0 immediately, no write, no done; a new load of 4 bytes then writes at BFC00000.
REQ-039 start pulsed during RECV -> ignored; length and addresses of the running load unchanged.
